pc_predict_unit: RTL and testbench

Fetch-address generator with a parametrised direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It sits at the front of the pipeline and drives the instruction-fetch address each cycle. It follows predicted-taken branches without waiting for resolution, and accepts redirects and training updates from the execute stage. Address width, reset vector, instruction step and BTB depth are parameters.

---
 rtl/pc_predict_unit.sv | 140 ++++++++++++++
 tb/tb_pc_predict_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_predict_unit.sv
// Fetch-address generator with a direct-mapped branch target buffer.
// Each entry keeps a valid bit, a tag, a taken target and a 2-bit
// saturating direction counter. Predicted-taken branches are followed
// immediately; the execute stage supplies redirects and training updates.
module pc_predict_unit #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    STEP        = 4,
    parameter int                    BTB_ENTRIES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall0,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    input  logic                  upd_valid,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic [ADDR_WIDTH-1:0] upd_target,
    output logic                  sending,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  pred_taken,
    output logic [ADDR_WIDTH-1:0] pred_target
);

    localparam int                    IDX    = $clog2(BTB_ENTRIES);
    localparam int                    TAG_W  = ADDR_WIDTH - IDX - 2;
    localparam logic [ADDR_WIDTH-1:0] STEP_A = ADDR_WIDTH'(STEP);

    // BTB storage; lookups are combinational so these stay in flops
    logic                  valid_reg  [BTB_ENTRIES];
    logic [TAG_W-1:0]      tag_reg    [BTB_ENTRIES];
    logic [ADDR_WIDTH-1:0] target_reg [BTB_ENTRIES];
    logic [1:0]            ctr_reg    [BTB_ENTRIES];

    // Fetch state
    logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
    logic [ADDR_WIDTH-1:0] pc_o_reg, pc_o_next;
    logic                  sending_reg;
    logic                  pred_taken_reg, pred_taken_next;
    logic [ADDR_WIDTH-1:0] pred_target_reg, pred_target_next;

    // Byte-offset bits never take part in indexing or tagging
    logic unused_bits;
    assign unused_bits = ^{upd_pc[1:0], pc_reg[1:0]};

    // Lookup on the address about to be issued
    logic [IDX-1:0]   look_idx;
    logic [TAG_W-1:0] look_tag;
    logic             look_hit;
    logic             look_taken;
    assign look_idx   = pc_reg[IDX+1:2];
    assign look_tag   = pc_reg[ADDR_WIDTH-1:IDX+2];
    assign look_hit   = valid_reg[look_idx] && (tag_reg[look_idx] == look_tag);
    assign look_taken = look_hit && (ctr_reg[look_idx] >= 2'd2);

    // Training-port decode
    logic [IDX-1:0]   upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    assign upd_idx = upd_pc[IDX+1:2];
    assign upd_tag = upd_pc[ADDR_WIDTH-1:IDX+2];
    assign upd_hit = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);

    // Per-entry training: saturating counters on hit, allocate on taken miss
    generate
        for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_btb
            always_ff @(posedge clock) begin
                if (reset) begin
                    valid_reg[gi]  <= 1'b0;
                    ctr_reg[gi]    <= 2'd0;
                    tag_reg[gi]    <= '0;
                    target_reg[gi] <= '0;
                end else if (upd_valid && (upd_idx == IDX'(gi))) begin
                    if (upd_hit) begin
                        if (upd_taken) begin
                            if (ctr_reg[gi] != 2'd3)
                                ctr_reg[gi] <= ctr_reg[gi] + 2'd1;
                            target_reg[gi] <= upd_target;
                        end else if (ctr_reg[gi] != 2'd0) begin
                            ctr_reg[gi] <= ctr_reg[gi] - 2'd1;
                        end
                    end else if (upd_taken) begin
                        valid_reg[gi]  <= 1'b1;
                        tag_reg[gi]    <= upd_tag;
                        target_reg[gi] <= upd_target;
                        ctr_reg[gi]    <= 2'd2;
                    end
                end
            end
        end
    endgenerate

    // Next fetch address and outputs: redirect beats stall beats normal
    always_comb begin
        pc_next          = pc_reg;
        pc_o_next        = pc_o_reg;
        pred_taken_next  = pred_taken_reg;
        pred_target_next = pred_target_reg;
        if (redirect) begin
            pc_o_next        = redirect_addr;
            pc_next          = redirect_addr + STEP_A;
            pred_taken_next  = 1'b0;
            pred_target_next = '0;
        end else if (!stall0) begin
            pc_o_next       = pc_reg;
            pred_taken_next = look_taken;
            if (look_taken) begin
                pred_target_next = target_reg[look_idx];
                pc_next          = target_reg[look_idx];
            end else begin
                pred_target_next = '0;
                pc_next          = pc_reg + STEP_A;
            end
        end
    end

    // Fetch state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_reg          <= RESET_PC;
            pc_o_reg        <= RESET_PC;
            sending_reg     <= 1'b0;
            pred_taken_reg  <= 1'b0;
            pred_target_reg <= '0;
        end else begin
            pc_reg          <= pc_next;
            pc_o_reg        <= pc_o_next;
            sending_reg     <= 1'b1;
            pred_taken_reg  <= pred_taken_next;
            pred_target_reg <= pred_target_next;
        end
    end

    assign sending     = sending_reg;
    assign pc_o        = pc_o_reg;
    assign pred_taken  = pred_taken_reg;
    assign pred_target = pred_target_reg;

endmodule

// File: tb/tb_pc_predict_unit.sv
// Scoreboard bench for pc_predict_unit: the driver pushes expected
// outputs from a reference model; a monitor pops and compares each cycle.
module tb_pc_predict_unit;

    localparam int          AW   = 32;
    localparam logic [31:0] RPC  = 32'h100;
    localparam int          NENT = 16;
    localparam int          IDXB = 4;

    logic        clock = 1'b0;
    logic        reset, stall0, redirect, upd_valid, upd_taken;
    logic [31:0] redirect_addr, upd_pc, upd_target;
    logic        sending, pred_taken;
    logic [31:0] pc_o, pred_target;

    pc_predict_unit #(
        .ADDR_WIDTH(AW), .RESET_PC(RPC), .STEP(4), .BTB_ENTRIES(NENT)
    ) dut (
        .clock(clock), .reset(reset), .stall0(stall0), .redirect(redirect),
        .redirect_addr(redirect_addr), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target), .sending(sending),
        .pc_o(pc_o), .pred_taken(pred_taken), .pred_target(pred_target)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        snd;
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ptg;
    } out_t;

    out_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    bit   stim_done = 0;

    // Reference model: next-fetch address, last outputs and a table of branches
    logic [31:0] m_pc;
    out_t        m_out;
    bit          b_valid [NENT];
    logic [31:0] b_tag   [NENT];
    logic [31:0] b_tgt   [NENT];
    int          b_ctr   [NENT];

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 4) % NENT);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a / (4 * NENT);
    endfunction

    task automatic model_step(input bit rst, input bit stl, input bit rdr,
                              input logic [31:0] ra, input bit uv,
                              input logic [31:0] up, input bit ut,
                              input logic [31:0] utg);
        int  i, j;
        bit  hit, tk;
        if (rst) begin
            m_pc  = RPC;
            m_out = '{snd: 1'b0, pc: RPC, pt: 1'b0, ptg: 32'h0};
            for (int k = 0; k < NENT; k++) begin
                b_valid[k] = 0;
                b_ctr[k]   = 0;
            end
        end else begin
            i   = idx_of(m_pc);
            hit = b_valid[i] && (b_tag[i] == tag_of(m_pc));
            tk  = hit && (b_ctr[i] >= 2);
            m_out.snd = 1'b1;
            if (rdr) begin
                m_out.pc  = ra;
                m_out.pt  = 1'b0;
                m_out.ptg = 32'h0;
                m_pc      = ra + 32'd4;
            end else if (!stl) begin
                m_out.pc  = m_pc;
                m_out.pt  = tk;
                m_out.ptg = tk ? b_tgt[i] : 32'h0;
                m_pc      = tk ? b_tgt[i] : m_pc + 32'd4;
            end
            if (uv) begin
                j = idx_of(up);
                if (b_valid[j] && b_tag[j] == tag_of(up)) begin
                    if (ut) begin
                        b_ctr[j] = (b_ctr[j] < 3) ? b_ctr[j] + 1 : 3;
                        b_tgt[j] = utg;
                    end else begin
                        b_ctr[j] = (b_ctr[j] > 0) ? b_ctr[j] - 1 : 0;
                    end
                end else if (ut) begin
                    b_valid[j] = 1;
                    b_tag[j]   = tag_of(up);
                    b_tgt[j]   = utg;
                    b_ctr[j]   = 2;
                end
            end
        end
        exp_q.push_back(m_out);
    endtask

    // Drive one cycle of inputs, record the expectation, move to the next negedge
    task automatic cyc(input bit rst, input bit stl, input bit rdr,
                       input logic [31:0] ra, input bit uv,
                       input logic [31:0] up, input bit ut,
                       input logic [31:0] utg);
        reset = rst; stall0 = stl; redirect = rdr; redirect_addr = ra;
        upd_valid = uv; upd_pc = up; upd_taken = ut; upd_target = utg;
        model_step(rst, stl, rdr, ra, uv, up, ut, utg);
        @(negedge clock);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic redir(input logic [31:0] a);
        cyc(0, 0, 1, a, 0, 0, 0, 0);
    endtask

    task automatic upd(input logic [31:0] p, input bit t, input logic [31:0] g);
        cyc(0, 1, 0, 0, 1, p, t, g);
    endtask

    // Monitor: one comparison per clock once outputs are expected
    initial begin
        out_t e;
        out_t a;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{snd: sending, pc: pc_o, pt: pred_taken, ptg: pred_target};
                checks++;
                if (a === e) passed++;
                else $display("FAIL out t=%0t got snd=%0b pc=%h pt=%0b tgt=%h want snd=%0b pc=%h pt=%0b tgt=%h",
                              $time, a.snd, a.pc, a.pt, a.ptg, e.snd, e.pc, e.pt, e.ptg);
            end else if (!stim_done) begin
                checks++;
                $display("FAIL queue t=%0t got empty want pending entry", $time);
            end
        end
    end

    initial begin
        logic [31:0] ra, up, ug;
        // Reset and sequential fetch
        cyc(1, 0, 0, 0, 1, 32'h10C, 1, 32'h999);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        run(3);
        // Stall holds, redirect under stall wins
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 32'h200, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        run(2);
        // Allocation and prediction
        upd(32'h10C, 1, 32'h400);
        redir(32'h108);
        run(4);
        // Counter hysteresis
        upd(32'h10C, 0, 0);
        redir(32'h108);
        run(3);
        upd(32'h10C, 1, 32'h400);
        upd(32'h10C, 1, 32'h400);
        upd(32'h10C, 0, 0);
        redir(32'h108);
        run(3);
        // Tag alias
        redir(32'h148);
        run(2);
        upd(32'h14C, 0, 0);
        redir(32'h108);
        run(3);
        // Same-cycle redirect and update to the looked-up entry
        cyc(0, 0, 1, 32'h10C, 1, 32'h10C, 1, 32'h500);
        redir(32'h108);
        run(3);
        // Wrap around the address space
        redir(32'hFFFF_FFF8);
        run(3);
        // Mid-run reset clears the table
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        run(1);
        redir(32'h108);
        run(3);
        // Randomised traffic in a small window so entries alias and retrain
        for (int k = 0; k < 400; k++) begin
            ra = 32'h100 + ($urandom_range(0, 31) * 4);
            up = 32'h100 + ($urandom_range(0, 31) * 4);
            ug = 32'h100 + ($urandom_range(0, 31) * 4);
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 9) == 0), ra, ($urandom_range(0, 9) < 4),
                up, $urandom_range(0, 1) == 1, ug);
        end
        stim_done = 1;
        @(posedge clock);
        #2;
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain got %0d left want 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
